ebpc_stream_arbiter: RTL and testbench
======================================

# ebpc_stream_arbiter

Shares one EBPC encoder between `N_IN` independent input streams. The block sits upstream of the encoder's data/last/vld/rdy input and grants it to one requester for a whole frame, from the first beat through the `last` beat. After the `last` beat it holds off all requesters until the encoder reports idle, so the ZNZ and BPC output streams of different frames never interleave. It publishes the owner ID, a per-frame beat count and a frame-done pulse so downstream logic can route the compressed streams.

## Interface
- `N_IN`, 4, number of requesters; legal range 2..16.
- `ID_W`, `$clog2(N_IN)`, width of the requester index (derived; do not override).
- `CNT_W`, 16, width of the beat counter.
- `clk_i`  in  1  clock.
- `rst_i`  in  1  asynchronous, active-high reset.
- `data_i`  in  `N_IN`×`DATA_W`  per-requester data words (`DATA_W` from `ebpc_pkg`).
- `last_i`  in  `N_IN`  per-requester last-beat flag.
- `vld_i`  in  `N_IN`  per-requester valid.
- `rdy_o`  out  `N_IN`  per-requester ready.
- `enc_data_o`  out  `DATA_W`  data to the encoder.
- `enc_last_o`  out  1  last flag to the encoder.
- `enc_vld_o`  out  1  valid to the encoder.
- `enc_rdy_i`  in  1  ready from the encoder.
- `enc_idle_i`  in  1  encoder `idle_o`.
- `grant_id_o`  out  `ID_W`  current owner index.
- `grant_vld_o`  out  1  `grant_id_o` is meaningful (states STREAM and DRAIN).
- `beat_cnt_o`  out  `CNT_W`  beats accepted in the current frame.
- `frame_done_o`  out  1  one-cycle pulse when the frame has fully drained.

## Operation
- State machine: IDLE, STREAM, DRAIN.
- Register `rr_ptr_q` (`ID_W` bits) holds the highest-priority index.
- **IDLE**
  - All `rdy_o`=0 and `enc_vld_o`=0.
  - If `enc_idle_i`=1 and any `vld_i` is set: the winner is the first set `vld_i` found scanning from `rr_ptr_q` upward, wrapping modulo `N_IN`.
  - On a win: register `gnt_q`=winner, clear `beat_cnt`, go to STREAM.
  - If `enc_idle_i`=0, no grant is made, whatever `vld_i` shows.
- **STREAM**
  - Pass-through, purely combinational:
    - `enc_data_o`=`data_i[gnt_q]`
    - `enc_last_o`=`last_i[gnt_q]`
    - `enc_vld_o`=`vld_i[gnt_q]`
    - `rdy_o[gnt_q]`=`enc_rdy_i`; all other `rdy_o`=0.
  - Each handshake (`enc_vld_o` and `enc_rdy_i` both high) increments `beat_cnt`, saturating at 2^`CNT_W`−1.
  - A handshake with `enc_last_o`=1 moves to DRAIN and sets `rr_ptr_q`=(`gnt_q`+1) mod `N_IN`.
- **DRAIN**
  - All `rdy_o`=0 and `enc_vld_o`=0.
  - The first DRAIN cycle ignores `enc_idle_i`, because the encoder drops idle only after accepting a beat.
  - From the second cycle on, `enc_idle_i`=1 causes `frame_done_o`=1 for that cycle and a move to IDLE.
  - `grant_id_o` and `beat_cnt_o` stay valid through the `frame_done_o` cycle.
- `beat_cnt_o` holds its value in IDLE until the next grant.
- Non-granted requesters may change `vld_i` and `data_i` freely; they are never acknowledged.

## Timing
- Reset values:
  - state=IDLE, `rr_ptr_q`=0, `gnt_q`=0, `beat_cnt`=0.
  - Outputs: `rdy_o`=0, `enc_vld_o`=0, `enc_data_o`=0, `enc_last_o`=0, `grant_vld_o`=0, `grant_id_o`=0, `beat_cnt_o`=0, `frame_done_o`=0.
- Latency:
  - Request to grant: 1 cycle. `vld_i` is sampled in IDLE in cycle t, and the first pass-through is possible in cycle t+1.
  - Data path adds zero cycles in STREAM; there is no buffering.
  - Minimum frame-to-frame gap: last handshake at t, DRAIN at t+1 and t+2, `frame_done_o` at the earliest in t+2, next grant in t+3, next STREAM in t+4.
- A single-beat frame (`last_i`=1 on the first beat) is legal: STREAM lasts one handshake, then DRAIN.
- When `enc_rdy_i`=0 in STREAM, the block stalls in place and `beat_cnt` is unchanged.
- If a requester drops `vld_i` mid-frame, the grant is kept; the block never preempts.
- Reset asserted mid-frame returns immediately to the reset values. The encoder is reset by the same signal; frame recovery is not supported.
- `enc_idle_i` is treated as synchronous to `clk_i`.

## Structure
- Reuse `DATA_W` from `ebpc_pkg`.
- Add the typedef `arb_state_t` (IDLE/STREAM/DRAIN) to `ebpc_pkg`.
- One sub-module: `rr_arbiter_comb`.
  - Inputs: request vector and `rr_ptr_q`.
  - Outputs: one-hot grant and encoded index.
  - Purely combinational, parameterised by `N_IN`.
- Everything else (FSM, counters, muxes) is inline.

## Test plan
- **Single requester:** `N_IN`=4; req 2 sends a 5-beat frame 0x01..0x05 with `last` on beat 5; `enc_rdy_i`=1; encoder model raises `enc_idle_i` 3 cycles after last.
  - Required: first `rdy_o[2]` one cycle after `vld_i`; `grant_id_o`=2; `beat_cnt_o`=5; one `frame_done_o` pulse.
- **Round-robin:** all 4 requesters present 2-beat frames continuously.
  - Required: grant order 0, 1, 2, 3, 0; no two frames overlap on the encoder port; `rdy_o` is never set for a non-owner.
- **Encoder busy:** `enc_idle_i`=0 while req 1 is valid.
  - Required: no grant and `rdy_o`=0 until `enc_idle_i` returns to 1; grant in the following cycle.
- **Backpressure and gaps:** `enc_rdy_i` toggles every cycle and req 0 deasserts `vld_i` for 3 cycles mid-frame.
  - Required: data order preserved; `beat_cnt_o` counts only handshakes; grant held throughout.
- **DRAIN corner:** `enc_idle_i` stuck at 1 after the last beat.
  - Required: exactly one ignored DRAIN cycle, then `frame_done_o` on the second DRAIN cycle.
- **Saturation and reset:** with `CNT_W`=4, a 20-beat frame gives `beat_cnt_o`=15. Asserting `rst_i` mid-frame gives all outputs 0 in the same cycle and `rr_ptr_q`=0, so the next grant goes to the lowest valid index.

Source files
------------

// File: rtl/ebpc_pkg.sv
// Shared EBPC definitions: datapath width and stream-arbiter state encoding.
// DATA_W is the encoder input word width; arb_state_t encodes IDLE/STREAM/DRAIN.
package ebpc_pkg;

    localparam int DATA_W = 8;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t ARB_IDLE   = 2'd0;
    localparam arb_state_t ARB_STREAM = 2'd1;
    localparam arb_state_t ARB_DRAIN  = 2'd2;

endpackage

// File: rtl/rr_arbiter_comb.sv
// Combinational round-robin pick: first set request at or above rr_ptr_i, wrapping.
// Ports: req_i requests, rr_ptr_i priority index, gnt_oh_o one-hot, gnt_idx_o index.
module rr_arbiter_comb #(
    parameter int N_IN = 4,
    parameter int ID_W = $clog2(N_IN)
) (
    input  logic [N_IN-1:0] req_i,
    input  logic [ID_W-1:0] rr_ptr_i,
    output logic [N_IN-1:0] gnt_oh_o,
    output logic [ID_W-1:0] gnt_idx_o
);

    logic            found;
    logic [ID_W-1:0] idx;

    always_comb begin
        gnt_oh_o  = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        idx       = '0;
        for (int i = 0; i < N_IN; i++) begin
            idx = ID_W'((int'(rr_ptr_i) + i) % N_IN);
            if (!found && req_i[idx]) begin
                found          = 1'b1;
                gnt_oh_o[idx]  = 1'b1;
                gnt_idx_o      = idx;
            end
        end
    end

endmodule

// File: rtl/ebpc_stream_arbiter.sv
// Frame-granular round-robin arbiter sharing one EBPC encoder among N_IN streams.
// Ports: per-requester data/last/vld/rdy, encoder data/last/vld/rdy/idle, grant/beat/done status.
module ebpc_stream_arbiter
    import ebpc_pkg::*;
#(
    parameter int N_IN  = 4,
    parameter int ID_W  = $clog2(N_IN),
    parameter int CNT_W = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [N_IN-1:0][DATA_W-1:0]  data_i,
    input  logic [N_IN-1:0]              last_i,
    input  logic [N_IN-1:0]              vld_i,
    output logic [N_IN-1:0]              rdy_o,
    output logic [DATA_W-1:0]            enc_data_o,
    output logic                         enc_last_o,
    output logic                         enc_vld_o,
    input  logic                         enc_rdy_i,
    input  logic                         enc_idle_i,
    output logic [ID_W-1:0]              grant_id_o,
    output logic                         grant_vld_o,
    output logic [CNT_W-1:0]             beat_cnt_o,
    output logic                         frame_done_o
);

    arb_state_t       state_q;
    logic [ID_W-1:0]  rr_ptr_q;
    logic [ID_W-1:0]  gnt_q;
    logic [CNT_W-1:0] beat_cnt_q;
    logic             drain_first_q;

    logic [N_IN-1:0]  arb_oh;
    logic [ID_W-1:0]  arb_idx;
    logic             start;
    logic             hs;
    logic [ID_W-1:0]  ptr_next;

    rr_arbiter_comb #(
        .N_IN (N_IN),
        .ID_W (ID_W)
    ) u_rr (
        .req_i     (vld_i),
        .rr_ptr_i  (rr_ptr_q),
        .gnt_oh_o  (arb_oh),
        .gnt_idx_o (arb_idx)
    );

    always_comb begin
        rdy_o      = '0;
        enc_data_o = '0;
        enc_last_o = 1'b0;
        enc_vld_o  = 1'b0;
        if (state_q == ARB_STREAM) begin
            enc_data_o   = data_i[gnt_q];
            enc_last_o   = last_i[gnt_q];
            enc_vld_o    = vld_i[gnt_q];
            rdy_o[gnt_q] = enc_rdy_i;
        end
    end

    assign hs    = enc_vld_o & enc_rdy_i;
    assign start = (state_q == ARB_IDLE) & enc_idle_i & (|arb_oh);

    assign ptr_next = (gnt_q == ID_W'(N_IN - 1)) ? '0 : gnt_q + 1'b1;

    assign grant_vld_o  = (state_q == ARB_STREAM) | (state_q == ARB_DRAIN);
    assign grant_id_o   = gnt_q;
    assign beat_cnt_o   = beat_cnt_q;
    // The encoder only drops idle after it has taken a beat, so the
    // first DRAIN cycle can still show a stale idle and must be skipped.
    assign frame_done_o = (state_q == ARB_DRAIN) & ~drain_first_q & enc_idle_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= ARB_IDLE;
            rr_ptr_q      <= '0;
            gnt_q         <= '0;
            beat_cnt_q    <= '0;
            drain_first_q <= 1'b0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (start) begin
                        gnt_q      <= arb_idx;
                        beat_cnt_q <= '0;
                        state_q    <= ARB_STREAM;
                    end
                end
                ARB_STREAM: begin
                    if (hs) begin
                        if (beat_cnt_q != '1) begin
                            beat_cnt_q <= beat_cnt_q + 1'b1;
                        end
                        if (enc_last_o) begin
                            state_q       <= ARB_DRAIN;
                            drain_first_q <= 1'b1;
                            rr_ptr_q      <= ptr_next;
                        end
                    end
                end
                ARB_DRAIN: begin
                    if (drain_first_q) begin
                        drain_first_q <= 1'b0;
                    end else if (enc_idle_i) begin
                        state_q <= ARB_IDLE;
                    end
                end
                default: begin
                    state_q <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ebpc_stream_arbiter.sv
// Self-checking bench for ebpc_stream_arbiter with requester and encoder models.
// Ports: none; drives the DUT with N_IN=4, CNT_W=4.
module tb_ebpc_stream_arbiter;
    import ebpc_pkg::*;

    localparam int N        = 4;
    localparam int IW       = 2;
    localparam int CW       = 4;
    localparam int IDLE_DLY = 3;
    localparam int SAT      = 15;

    typedef logic [DATA_W:0] beat_t;

    logic                      clk_i = 1'b0;
    logic                      rst_i;
    logic [N-1:0][DATA_W-1:0]  data_i;
    logic [N-1:0]              last_i;
    logic [N-1:0]              vld_i;
    logic [N-1:0]              rdy_o;
    logic [DATA_W-1:0]         enc_data_o;
    logic                      enc_last_o;
    logic                      enc_vld_o;
    logic                      enc_rdy_i;
    logic                      enc_idle_i;
    logic [IW-1:0]             grant_id_o;
    logic                      grant_vld_o;
    logic [CW-1:0]             beat_cnt_o;
    logic                      frame_done_o;

    ebpc_stream_arbiter #(
        .N_IN  (N),
        .CNT_W (CW)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .data_i       (data_i),
        .last_i       (last_i),
        .vld_i        (vld_i),
        .rdy_o        (rdy_o),
        .enc_data_o   (enc_data_o),
        .enc_last_o   (enc_last_o),
        .enc_vld_o    (enc_vld_o),
        .enc_rdy_i    (enc_rdy_i),
        .enc_idle_i   (enc_idle_i),
        .grant_id_o   (grant_id_o),
        .grant_vld_o  (grant_vld_o),
        .beat_cnt_o   (beat_cnt_o),
        .frame_done_o (frame_done_o)
    );

    always #5 clk_i = ~clk_i;

    int     checks = 0;
    int     failures = 0;
    beat_t  rq [N][$];
    beat_t  exp_q [N][$];
    int     flen_q [N][$];
    int     order_q [$];
    logic [N-1:0] req_en = '1;
    bit     force_busy = 0;
    bit     stuck_idle = 0;
    bit     rdy_toggle = 0;
    bit     enc_busy = 0;
    int     cd = 0;
    int     cyc = 0;
    int     done_cnt = 0;
    bit     in_frame = 0;
    int     cur_owner = 0;

    task automatic push_frame(input int r, input int len, input int base);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b = {(i == len - 1), DATA_W'(base + i)};
            rq[r].push_back(b);
            exp_q[r].push_back(b);
        end
        flen_q[r].push_back(len > SAT ? SAT : len);
    endtask

    task automatic drive();
        for (int r = 0; r < N; r++) begin
            if (rq[r].size() != 0 && req_en[r]) begin
                vld_i[r]  = 1'b1;
                data_i[r] = rq[r][0][DATA_W-1:0];
                last_i[r] = rq[r][0][DATA_W];
            end else begin
                vld_i[r]  = 1'b0;
                data_i[r] = DATA_W'($urandom);
                last_i[r] = 1'b0;
            end
        end
        enc_rdy_i  = rdy_toggle ? cyc[0] : 1'b1;
        enc_idle_i = stuck_idle ? 1'b1 : !(enc_busy || force_busy);
        #1;
    endtask

    task automatic advance();
        logic [N-1:0] own;
        beat_t        e;
        int           o;
        own = '0;
        if (grant_vld_o) own[grant_id_o] = 1'b1;
        checks++;
        if ((rdy_o & ~own) !== '0) begin
            failures++;
            $display("FAIL non_owner_rdy: rdy_o=%b owner_mask=%b", rdy_o, own);
        end
        for (int r = 0; r < N; r++) begin
            if (rdy_o[r] && vld_i[r]) void'(rq[r].pop_front());
        end
        if (enc_vld_o && enc_rdy_i) begin
            o = int'(grant_id_o);
            checks++;
            if (exp_q[o].size() == 0) begin
                failures++;
                $display("FAIL hs_unexpected: got beat %h from %0d want none", {enc_last_o, enc_data_o}, o);
            end else begin
                e = exp_q[o].pop_front();
                if ({enc_last_o, enc_data_o} !== e) begin
                    failures++;
                    $display("FAIL beat_data: got %h want %h (req %0d)", {enc_last_o, enc_data_o}, e, o);
                end
            end
            checks++;
            if (in_frame && o != cur_owner) begin
                failures++;
                $display("FAIL frame_overlap: got owner %0d want %0d", o, cur_owner);
            end
            in_frame  = 1;
            cur_owner = o;
            enc_busy  = 1;
            cd        = enc_last_o ? IDLE_DLY - 1 : 0;
        end else if (cd > 0) begin
            cd--;
            if (cd == 0) enc_busy = 0;
        end
        if (frame_done_o) begin
            o = int'(grant_id_o);
            checks++;
            if (!in_frame || o != cur_owner) begin
                failures++;
                $display("FAIL done_owner: got %0d want %0d (in_frame=%0d)", o, cur_owner, in_frame);
            end
            checks++;
            if (flen_q[o].size() == 0) begin
                failures++;
                $display("FAIL done_unexpected: got done for %0d want none", o);
            end else begin
                e = beat_t'(flen_q[o].pop_front());
                if (beat_cnt_o !== CW'(e)) begin
                    failures++;
                    $display("FAIL beat_cnt: got %0d want %0d", beat_cnt_o, e);
                end
            end
            order_q.push_back(o);
            done_cnt++;
            in_frame = 0;
        end
        cyc++;
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic run_frames(input int target, input int budget);
        int n;
        n = 0;
        while (done_cnt < target && n < budget) begin
            drive();
            advance();
            n++;
        end
        checks++;
        if (done_cnt < target) begin
            failures++;
            $display("FAIL timeout: got %0d frames want %0d", done_cnt, target);
        end
    endtask

    task automatic apply_reset();
        rst_i = 1'b1;
        for (int r = 0; r < N; r++) begin
            rq[r].delete();
            exp_q[r].delete();
            flen_q[r].delete();
        end
        order_q.delete();
        enc_busy   = 0;
        cd         = 0;
        in_frame   = 0;
        req_en     = '1;
        force_busy = 0;
        stuck_idle = 0;
        rdy_toggle = 0;
        drive();
        @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        drive();
        checks++;
        if ({rdy_o, enc_vld_o, enc_data_o, enc_last_o, grant_vld_o, grant_id_o, beat_cnt_o, frame_done_o} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got rdy=%b vld=%b data=%h gv=%b id=%0d cnt=%0d want all 0",
                     rdy_o, enc_vld_o, enc_data_o, grant_vld_o, grant_id_o, beat_cnt_o);
        end
        @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        drive();
        checks++;
        if ({rdy_o, enc_vld_o, grant_vld_o, beat_cnt_o, frame_done_o} !== '0) begin
            failures++;
            $display("FAIL post_reset_idle: got rdy=%b vld=%b gv=%b cnt=%0d want 0", rdy_o, enc_vld_o, grant_vld_o, beat_cnt_o);
        end
        advance();
    endtask

    task automatic test_single();
        int d0;
        int pulses;
        d0 = done_cnt;
        push_frame(2, 5, 1);
        drive();
        checks++;
        if (rdy_o !== '0) begin
            failures++;
            $display("FAIL single_req_cycle: got rdy=%b want 0000", rdy_o);
        end
        advance();
        drive();
        checks++;
        if (rdy_o !== 4'b0100 || grant_id_o !== 2'd2 || !grant_vld_o) begin
            failures++;
            $display("FAIL single_grant: got rdy=%b id=%0d gv=%b want 0100/2/1", rdy_o, grant_id_o, grant_vld_o);
        end
        advance();
        run_frames(d0 + 1, 60);
        for (int i = 0; i < 5; i++) begin
            drive();
            advance();
        end
        pulses = done_cnt - d0;
        checks++;
        if (pulses != 1) begin
            failures++;
            $display("FAIL single_pulses: got %0d want 1", pulses);
        end
        drive();
        checks++;
        if (beat_cnt_o !== 4'd5 || grant_vld_o !== 1'b0) begin
            failures++;
            $display("FAIL single_hold: got cnt=%0d gv=%b want 5/0", beat_cnt_o, grant_vld_o);
        end
        advance();
    endtask

    task automatic test_round_robin();
        int want [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
        int d0;
        apply_reset();
        d0 = done_cnt;
        for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < N; r++) push_frame(r, 2, 16 * r + 8 * k);
        end
        run_frames(d0 + 8, 400);
        checks++;
        if (order_q.size() != 8) begin
            failures++;
            $display("FAIL rr_count: got %0d want 8", order_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (order_q[i] != want[i]) begin
                    failures++;
                    $display("FAIL rr_order[%0d]: got %0d want %0d", i, order_q[i], want[i]);
                end
            end
        end
    endtask

    task automatic test_enc_busy();
        int d0;
        d0 = done_cnt;
        force_busy = 1;
        push_frame(1, 1, 8'hA5);
        for (int i = 0; i < 5; i++) begin
            drive();
            checks++;
            if (rdy_o !== '0 || grant_vld_o !== 1'b0) begin
                failures++;
                $display("FAIL busy_hold: got rdy=%b gv=%b want 0/0", rdy_o, grant_vld_o);
            end
            advance();
        end
        force_busy = 0;
        drive();
        checks++;
        if (rdy_o !== '0) begin
            failures++;
            $display("FAIL busy_release: got rdy=%b want 0000", rdy_o);
        end
        advance();
        drive();
        checks++;
        if (rdy_o !== 4'b0010 || grant_id_o !== 2'd1) begin
            failures++;
            $display("FAIL busy_grant: got rdy=%b id=%0d want 0010/1", rdy_o, grant_id_o);
        end
        advance();
        run_frames(d0 + 1, 40);
    endtask

    task automatic test_backpressure();
        int  d0;
        int  hsn;
        int  gap_left;
        bit  gap_used;
        bit  seen;
        int  n;
        d0 = done_cnt;
        hsn = 0;
        gap_left = 0;
        gap_used = 0;
        seen = 0;
        n = 0;
        rdy_toggle = 1;
        push_frame(0, 8, 8'h40);
        while (done_cnt == d0 && n < 200) begin
            req_en[0] = (gap_left == 0);
            drive();
            if (grant_vld_o) seen = 1;
            if (seen) begin
                checks++;
                if (grant_vld_o !== 1'b1 || grant_id_o !== 2'd0 || beat_cnt_o !== CW'(hsn)) begin
                    failures++;
                    $display("FAIL bp_hold: got gv=%b id=%0d cnt=%0d want 1/0/%0d", grant_vld_o, grant_id_o, beat_cnt_o, hsn);
                end
            end
            if (enc_vld_o && enc_rdy_i) hsn++;
            advance();
            if (hsn == 3 && !gap_used) begin
                gap_left = 3;
                gap_used = 1;
            end else if (gap_left > 0) begin
                gap_left--;
            end
            n++;
        end
        checks++;
        if (hsn != 8 || done_cnt != d0 + 1) begin
            failures++;
            $display("FAIL bp_total: got hs=%0d frames=%0d want 8/1", hsn, done_cnt - d0);
        end
        rdy_toggle = 0;
        req_en = '1;
    endtask

    task automatic test_drain_corner();
        bit h;
        int n;
        h = 0;
        n = 0;
        stuck_idle = 1;
        push_frame(3, 1, 8'h3C);
        while (!h && n < 20) begin
            drive();
            h = enc_vld_o && enc_rdy_i;
            advance();
            n++;
        end
        checks++;
        if (!h) begin
            failures++;
            $display("FAIL drain_hs: got no handshake want one");
        end
        drive();
        checks++;
        if (frame_done_o !== 1'b0 || grant_vld_o !== 1'b1) begin
            failures++;
            $display("FAIL drain_first: got done=%b gv=%b want 0/1", frame_done_o, grant_vld_o);
        end
        advance();
        drive();
        checks++;
        if (frame_done_o !== 1'b1 || grant_id_o !== 2'd3) begin
            failures++;
            $display("FAIL drain_second: got done=%b id=%0d want 1/3", frame_done_o, grant_id_o);
        end
        advance();
        drive();
        checks++;
        if (frame_done_o !== 1'b0 || grant_vld_o !== 1'b0) begin
            failures++;
            $display("FAIL drain_exit: got done=%b gv=%b want 0/0", frame_done_o, grant_vld_o);
        end
        advance();
        stuck_idle = 0;
    endtask

    task automatic test_saturation_reset();
        int d0;
        int hsn;
        int n;
        d0 = done_cnt;
        push_frame(1, 20, 8'h80);
        run_frames(d0 + 1, 200);
        drive();
        checks++;
        if (beat_cnt_o !== 4'd15) begin
            failures++;
            $display("FAIL sat_hold: got %0d want 15", beat_cnt_o);
        end
        advance();
        push_frame(2, 6, 8'h10);
        hsn = 0;
        n = 0;
        while (hsn < 3 && n < 50) begin
            drive();
            if (enc_vld_o && enc_rdy_i) hsn++;
            advance();
            n++;
        end
        drive();
        rst_i = 1'b1;
        #1;
        checks++;
        if ({rdy_o, enc_vld_o, enc_data_o, enc_last_o, grant_vld_o, grant_id_o, beat_cnt_o, frame_done_o} !== '0) begin
            failures++;
            $display("FAIL mid_reset: got rdy=%b vld=%b data=%h gv=%b id=%0d cnt=%0d want all 0",
                     rdy_o, enc_vld_o, enc_data_o, grant_vld_o, grant_id_o, beat_cnt_o);
        end
        apply_reset();
        d0 = done_cnt;
        push_frame(3, 1, 8'hC3);
        push_frame(1, 1, 8'hC1);
        drive();
        advance();
        drive();
        checks++;
        if (grant_id_o !== 2'd1 || rdy_o !== 4'b0010) begin
            failures++;
            $display("FAIL post_reset_ptr: got id=%0d rdy=%b want 1/0010", grant_id_o, rdy_o);
        end
        advance();
        run_frames(d0 + 2, 60);
    endtask

    initial begin
        rst_i      = 1'b1;
        vld_i      = '0;
        last_i     = '0;
        data_i     = '0;
        enc_rdy_i  = 1'b1;
        enc_idle_i = 1'b1;
        @(negedge clk_i);
        test_reset();
        test_single();
        test_round_robin();
        test_enc_busy();
        test_backpressure();
        test_drain_corner();
        test_saturation_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
